// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC transmit framer.
package hdlc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OPEN_FLAG,
    DATA,
    FCS,
    CLOSE_FLAG,
    ABORT,
    FLUSH
  } state_t;

  localparam logic [7:0]  FLAG_BYTE  = 8'h7E;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
  // Five consecutive 1s in data/FCS force an inserted 0.
  localparam logic [2:0]  STUFF_RUN  = 3'd5;

  // Number of FCS bits on the wire for the selected CRC.
  function automatic logic [5:0] fcs_len(input logic use32);
    return use32 ? 6'd32 : 6'd16;
  endfunction

endpackage

// File: rtl/hdlc_crc_gen.sv
// Serial CRC generator: preset, per-bit update, and MSB-first shift-out of the
// complemented register. The register is kept in non-reflected form; feeding the
// wire bits (LSB first) into it gives the reflected-input CRC, and shifting it out
// MSB first puts the reflected FCS on the wire LSB first.
module hdlc_crc_gen
  import hdlc_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC16_POLY),
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(CRC16_INIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic preset,
  input  logic update,
  input  logic din,
  input  logic shift,
  output logic dout
);

  logic [WIDTH-1:0] crc;

  // CRC register, clocked on the falling bit-clock edge like the framer.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= INIT;
    end else if (preset) begin
      crc <= INIT;
    end else if (update) begin
      crc <= {crc[WIDTH-2:0], 1'b0} ^ ((din ^ crc[WIDTH-1]) ? POLY : '0);
    end else if (shift) begin
      crc <= {crc[WIDTH-2:0], 1'b1};
    end
  end

  assign dout = ~crc[WIDTH-1];

endmodule

// File: rtl/hdlc_tx_framer_mc.sv
// HDLC/SDLC bit-serial transmit framer: flags, zero-stuffed data, CRC-16 FCS
// (CRC-32 too when HDLC_TX_CRC32_EN is defined), closing/inter-frame flags,
// host abort and post-underrun flush. All state moves on the falling netclk edge.
//
// Handshake: tx_ready is combinational and may depend on tx_valid. It is high in
// the cycle before the falling edge that takes tx_data; a byte is transferred at
// that edge exactly when tx_valid && tx_ready. tx_data/tx_last must stay stable
// while tx_valid is high and no transfer has happened.
module hdlc_tx_framer_mc
  import hdlc_pkg::*;
#(
  parameter int MIN_IFG_FLAGS = 1,
  parameter int FLAG_SHARE    = 0,
  parameter int ABORT_ONES    = 7
) (
  input  logic       netclk,
  input  logic       reset_n,
  output logic       txdata,
  input  logic       flag_fill,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       crc32_sel,
  input  logic       abort_req,
  output logic       underrun,
  output logic       frame_done,
  output logic       busy,
  output state_t     dbg_state
);

  localparam logic [5:0] ABORT_LAST = 6'(ABORT_ONES);
  localparam logic [3:0] IFG_LAST   = 4'(MIN_IFG_FLAGS - 1);

  state_t     state, state_n;
  logic [5:0] bit_cnt, bit_cnt_n;
  logic [3:0] flag_cnt, flag_cnt_n;
  logic [2:0] ones_cnt, ones_n;
  logic [7:0] shreg, shreg_n;
  logic       held_last, held_last_n;
  logic       txbit, ready, preset, crc_upd, crc_shift;
  logic       underrun_n, frame_done_n, open_entry;
  logic       use32, crc16_out, crc32_out, fcs_bit;
  logic [5:0] fcs_bits;

  hdlc_crc_gen #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clk(netclk), .rst_n(reset_n), .preset(preset), .update(crc_upd),
    .din(txbit), .shift(crc_shift), .dout(crc16_out)
  );

`ifdef HDLC_TX_CRC32_EN
  hdlc_crc_gen #(.WIDTH(32), .POLY(CRC32_POLY), .INIT(CRC32_INIT)) u_crc32 (
    .clk(netclk), .rst_n(reset_n), .preset(preset), .update(crc_upd),
    .din(txbit), .shift(crc_shift), .dout(crc32_out)
  );

  // CRC width choice is captured when a frame opens and held to its end.
  always_ff @(negedge netclk or negedge reset_n) begin
    if (!reset_n) use32 <= 1'b0;
    else if (open_entry) use32 <= crc32_sel;
  end
`else
  logic unused_crc32_sel;
  assign unused_crc32_sel = crc32_sel;
  assign crc32_out        = 1'b1;
  assign use32            = 1'b0;
`endif

  assign fcs_bits  = fcs_len(use32);
  assign fcs_bit   = use32 ? crc32_out : crc16_out;
  assign tx_ready  = ready;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Framer state, counters and registered line/pulse outputs.
  always_ff @(negedge netclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      flag_cnt   <= '0;
      ones_cnt   <= '0;
      shreg      <= '0;
      held_last  <= 1'b0;
      txdata     <= 1'b1;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      flag_cnt   <= flag_cnt_n;
      ones_cnt   <= ones_n;
      shreg      <= shreg_n;
      held_last  <= held_last_n;
      txdata     <= txbit;
      underrun   <= underrun_n;
      frame_done <= frame_done_n;
    end
  end

  // Next-state logic: each edge emits exactly one line bit (txbit).
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    flag_cnt_n   = flag_cnt;
    ones_n       = ones_cnt;
    shreg_n      = shreg;
    held_last_n  = held_last;
    txbit        = 1'b1;
    ready        = 1'b0;
    preset       = 1'b0;
    crc_upd      = 1'b0;
    crc_shift    = 1'b0;
    underrun_n   = 1'b0;
    frame_done_n = 1'b0;
    open_entry   = 1'b0;
    case (state)
      IDLE: begin
        if (bit_cnt != 6'd0) begin
          // finish a fill flag that has already started
          txbit     = FLAG_BYTE[bit_cnt[2:0]];
          bit_cnt_n = (bit_cnt == 6'd7) ? 6'd0 : bit_cnt + 6'd1;
        end else if (tx_valid) begin
          txbit      = FLAG_BYTE[0];
          bit_cnt_n  = 6'd1;
          state_n    = OPEN_FLAG;
          open_entry = 1'b1;
        end else if (flag_fill) begin
          txbit     = FLAG_BYTE[0];
          bit_cnt_n = 6'd1;
        end
      end
      OPEN_FLAG: begin
        txbit = FLAG_BYTE[bit_cnt[2:0]];
        if (bit_cnt == 6'd7) begin
          bit_cnt_n = 6'd0;
          if (tx_valid) begin
            ready       = 1'b1;
            shreg_n     = tx_data;
            held_last_n = tx_last;
            preset      = 1'b1;
            ones_n      = 3'd0;
            state_n     = DATA;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + 6'd1;
        end
      end
      DATA: begin
        if (ones_cnt == STUFF_RUN) begin
          txbit  = 1'b0;
          ones_n = 3'd0;
          if (abort_req) begin
            state_n   = ABORT;
            bit_cnt_n = 6'd0;
          end
        end else begin
          txbit   = shreg[0];
          shreg_n = {1'b0, shreg[7:1]};
          crc_upd = 1'b1;
          ones_n  = shreg[0] ? ones_cnt + 3'd1 : 3'd0;
          if (bit_cnt == 6'd7) begin
            bit_cnt_n = 6'd0;
            if (!held_last && !tx_valid) underrun_n = 1'b1;
            if (abort_req || (!held_last && !tx_valid)) begin
              state_n = ABORT;
            end else if (held_last) begin
              state_n = FCS;
            end else begin
              ready       = 1'b1;
              shreg_n     = tx_data;
              held_last_n = tx_last;
            end
          end else begin
            bit_cnt_n = bit_cnt + 6'd1;
            if (abort_req) begin
              state_n   = ABORT;
              bit_cnt_n = 6'd0;
            end
          end
        end
      end
      FCS: begin
        if (ones_cnt == STUFF_RUN) begin
          txbit  = 1'b0;
          ones_n = 3'd0;
          if (bit_cnt == fcs_bits) begin
            // trailing stuff bit after the last FCS bit
            state_n    = CLOSE_FLAG;
            bit_cnt_n  = 6'd0;
            flag_cnt_n = 4'd0;
          end else if (abort_req) begin
            state_n   = ABORT;
            bit_cnt_n = 6'd0;
          end
        end else begin
          txbit     = fcs_bit;
          crc_shift = 1'b1;
          ones_n    = fcs_bit ? ones_cnt + 3'd1 : 3'd0;
          bit_cnt_n = bit_cnt + 6'd1;
          if (abort_req) begin
            state_n   = ABORT;
            bit_cnt_n = 6'd0;
          end else if (bit_cnt == fcs_bits - 6'd1) begin
            frame_done_n = 1'b1;
            if (ones_n != STUFF_RUN) begin
              state_n    = CLOSE_FLAG;
              bit_cnt_n  = 6'd0;
              flag_cnt_n = 4'd0;
            end
          end
        end
      end
      CLOSE_FLAG: begin
        txbit = FLAG_BYTE[bit_cnt[2:0]];
        if (bit_cnt == 6'd7) begin
          bit_cnt_n = 6'd0;
          if (flag_cnt == IFG_LAST) begin
            flag_cnt_n = 4'd0;
            if ((FLAG_SHARE != 0) && tx_valid) begin
              ready       = 1'b1;
              shreg_n     = tx_data;
              held_last_n = tx_last;
              preset      = 1'b1;
              ones_n      = 3'd0;
              open_entry  = 1'b1;
              state_n     = DATA;
            end else if (tx_valid) begin
              open_entry = 1'b1;
              state_n    = OPEN_FLAG;
            end else begin
              state_n = IDLE;
            end
          end else begin
            flag_cnt_n = flag_cnt + 4'd1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 6'd1;
        end
      end
      ABORT: begin
        txbit = (bit_cnt != 6'd0);
        if (bit_cnt == ABORT_LAST) begin
          bit_cnt_n  = 6'd0;
          flag_cnt_n = 4'd0;
          state_n    = held_last ? CLOSE_FLAG : FLUSH;
        end else begin
          bit_cnt_n = bit_cnt + 6'd1;
        end
      end
      FLUSH: begin
        txbit = 1'b1;
        if (tx_valid) begin
          ready = 1'b1;
          if (tx_last) begin
            state_n    = CLOSE_FLAG;
            bit_cnt_n  = 6'd0;
            flag_cnt_n = 4'd0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hdlc_tx_framer_mc.sv
// Directed bench for hdlc_tx_framer_mc (FLAG_SHARE=1, MIN_IFG_FLAGS=1).
// The line is recorded on every rising edge and decoded (flag search, de-stuffing).
module tb_hdlc_tx_framer_mc;
  import hdlc_pkg::*;

  logic       netclk = 1'b0;
  logic       reset_n, txdata, flag_fill, tx_valid, tx_last, tx_ready;
  logic       crc32_sel, abort_req, underrun, frame_done, busy;
  logic [7:0] tx_data;
  state_t     dbg_state;

  logic       raw_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];
  int n_checks = 0, n_fail = 0;
  int n_ready = 0, n_fd = 0, n_ur = 0;

  hdlc_tx_framer_mc #(.MIN_IFG_FLAGS(1), .FLAG_SHARE(1), .ABORT_ONES(7)) dut (
    .netclk(netclk), .reset_n(reset_n), .txdata(txdata), .flag_fill(flag_fill),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .crc32_sel(crc32_sel), .abort_req(abort_req), .underrun(underrun),
    .frame_done(frame_done), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 netclk = ~netclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // line recorder and pulse counters, sampled mid-cycle
  always @(posedge netclk) begin
    raw_q.push_back(txdata);
    if (tx_ready)   n_ready++;
    if (frame_done) n_fd++;
    if (underrun)   n_ur++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", tag);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge netclk);
    #1;
  endtask

  // present one byte and hold it until it is taken (returns just after that edge)
  task automatic send_byte(input logic [7:0] d, input logic last);
    int t;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    t = 0;
    while (t < 400) begin
      @(posedge netclk);
      if (tx_ready) break;
      t++;
    end
    if (t >= 400) timeout_fail("send_byte");
    @(negedge netclk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (t < 3000) begin
      @(posedge netclk);
      if (!busy) break;
      t++;
    end
    if (t >= 3000) timeout_fail(tag);
    tick(3);
  endtask

  function automatic logic [7:0] raw_byte(input int p);
    logic [7:0] v;
    for (int i = 0; i < 8; i++)
      v[i] = (p >= 0 && p + i < raw_q.size()) ? raw_q[p + i] : 1'bx;
    return v;
  endfunction

  function automatic logic is_flag(input int p);
    if (p < 0 || p + 8 > raw_q.size()) return 1'b0;
    return (raw_byte(p) == 8'h7E);
  endfunction

  function automatic int find_flag(input int start);
    for (int p = start; p + 8 <= raw_q.size(); p++)
      if (is_flag(p)) return p;
    return -1;
  endfunction

  // decode one frame after the first flag at/after start; fend = closing flag index
  task automatic decode_frame(input int start, output int fend);
    int p, ones, nb;
    logic [7:0] acc;
    dec_q.delete();
    fend = -1;
    p = find_flag(start);
    if (p < 0) return;
    while (is_flag(p)) p += 8;
    ones = 0; nb = 0; acc = '0;
    while (p + 8 <= raw_q.size() && !is_flag(p)) begin
      if (ones == 5) begin
        ones = 0;
        p++;
      end else begin
        acc[nb] = raw_q[p];
        ones = raw_q[p] ? ones + 1 : 0;
        nb++;
        p++;
        if (nb == 8) begin
          dec_q.push_back(acc);
          nb = 0;
          acc = '0;
        end
      end
    end
    if (is_flag(p)) fend = p;
  endtask

  // scoreboard: compare decoded frame against exp_q
  task automatic check_frame(input string tag, input int start, output int fend);
    int n;
    decode_frame(start, fend);
    check_eq({tag, "_len"}, dec_q.size(), exp_q.size());
    check_eq({tag, "_closing_flag"}, (fend >= 0), 1);
    n = 0;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check_eq($sformatf("%s_byte%0d", tag, n), (n < dec_q.size()) ? dec_q[n] : 8'hxx, e);
      n++;
    end
  endtask

  initial begin
    int start, p, fend, base_ready, base_fd, base_ur, ones;
    logic [7:0] msg [9];
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    // reset
    reset_n = 1'b0; flag_fill = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;
    tx_data = '0; crc32_sel = 1'b0; abort_req = 1'b0;
    tick(3);
    check_eq("rst_txdata", txdata, 1);
    check_eq("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick(1);
    check_eq("rst_ready", tx_ready, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_frame_done", frame_done, 0);

    // 1: idle mark line
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge netclk);
      if (txdata === 1'b1 && busy === 1'b0) ones++;
    end
    check_eq("idle_mark_cycles", ones, 20);

    // idle flag fill: back-to-back 7E, starting on the next emitted bit
    tick(1);
    start = raw_q.size();
    flag_fill = 1'b1;
    tick(18);
    p = find_flag(start);
    check_eq("fill_phase", p - start, 1);
    check_eq("fill_flag2", raw_byte(p + 8), 8'h7E);
    check_eq("fill_busy", busy, 0);
    flag_fill = 1'b0;
    tick(12);

    // 2: "123456789" with CRC-16
    start = raw_q.size();
    base_fd = n_fd;
    for (int i = 0; i < 9; i++) send_byte(msg[i], (i == 8));
    tx_valid = 1'b0;
    wait_idle("crc16_idle");
    check_eq("crc16_frame_done", n_fd - base_fd, 1);
    for (int i = 0; i < 9; i++) exp_q.push_back(msg[i]);
    exp_q.push_back(8'h6E);
    exp_q.push_back(8'h90);
    check_frame("crc16", start, fend);

`ifdef HDLC_TX_CRC32_EN
    // 3: same frame, CRC-32
    start = raw_q.size();
    crc32_sel = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(msg[i], (i == 8));
    tx_valid = 1'b0;
    crc32_sel = 1'b0;
    wait_idle("crc32_idle");
    for (int i = 0; i < 9; i++) exp_q.push_back(msg[i]);
    exp_q.push_back(8'h26);
    exp_q.push_back(8'h39);
    exp_q.push_back(8'hF4);
    exp_q.push_back(8'hCB);
    check_frame("crc32", start, fend);
`endif

    // 4: zero stuffing, 0xFF then 0x7E as payload
    start = raw_q.size();
    send_byte(8'hFF, 1'b1);
    tx_valid = 1'b0;
    wait_idle("stuff_ff_idle");
    p = find_flag(start);
    check_eq("stuff_ff_wire", {raw_q[p+16], raw_byte(p + 8)}, 9'h1DF);
    decode_frame(start, fend);
    check_eq("stuff_ff_len", dec_q.size(), 3);
    check_eq("stuff_ff_byte", dec_q[0], 8'hFF);

    start = raw_q.size();
    send_byte(8'h7E, 1'b1);
    tx_valid = 1'b0;
    wait_idle("stuff_7e_idle");
    p = find_flag(start);
    check_eq("stuff_7e_wire", {raw_q[p+16], raw_byte(p + 8)}, 9'h0BE);
    decode_frame(start, fend);
    check_eq("stuff_7e_byte", dec_q[0], 8'h7E);

    // 5: underrun after byte 2 of 4, abort, flush of bytes 3-4
    start = raw_q.size();
    base_ready = n_ready; base_fd = n_fd; base_ur = n_ur;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    tx_valid = 1'b0;
    begin
      int t;
      t = 0;
      while (t < 100 && n_ur == base_ur) begin
        @(posedge netclk);
        t++;
      end
      if (n_ur == base_ur) timeout_fail("underrun_wait");
    end
    check_eq("underrun_pulses", n_ur - base_ur, 1);
    tick(12);
    check_eq("flush_txdata", txdata, 1);
    check_eq("flush_busy", busy, 1);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    tx_valid = 1'b0;
    wait_idle("flush_idle");
    check_eq("underrun_ready_count", n_ready - base_ready, 4);
    check_eq("underrun_no_frame_done", n_fd - base_fd, 0);
    p = find_flag(start);
    check_eq("underrun_byte1", raw_byte(p + 8), 8'h01);
    check_eq("underrun_byte2", raw_byte(p + 16), 8'h02);
    check_eq("underrun_abort_seq", raw_byte(p + 24), 8'hFE);
    check_eq("underrun_flush_mark", raw_q[p + 32], 1);
    check_eq("underrun_close_flag", (find_flag(p + 32) > 0), 1);

    // host abort mid-byte
    start = raw_q.size();
    base_fd = n_fd; base_ur = n_ur;
    send_byte(8'h55, 1'b0);
    tx_valid = 1'b0;
    tick(3);
    abort_req = 1'b1;
    tick(1);
    abort_req = 1'b0;
    tick(12);
    check_eq("abort_flush_busy", busy, 1);
    send_byte(8'h99, 1'b1);
    tx_valid = 1'b0;
    wait_idle("abort_idle");
    p = find_flag(start);
    check_eq("abort_seq", raw_byte(p + 12), 8'hFE);
    check_eq("abort_no_frame_done", n_fd - base_fd, 0);
    check_eq("abort_no_underrun", n_ur - base_ur, 0);

    // 6: back-to-back frames with a shared flag
    start = raw_q.size();
    base_fd = n_fd;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tx_valid = 1'b0;
    wait_idle("share_idle");
    check_eq("share_frame_done", n_fd - base_fd, 2);
    decode_frame(start, fend);
    check_eq("share_a_len", dec_q.size(), 3);
    check_eq("share_a_byte", dec_q[0], 8'h11);
    check_eq("share_single_flag", raw_byte(fend), 8'h7E);
    check_eq("share_next_data", raw_byte(fend + 8), 8'h22);
    decode_frame(fend, fend);
    check_eq("share_b_len", dec_q.size(), 3);

    // reset asserted mid-FCS
    base_fd = n_fd;
    send_byte(8'h33, 1'b1);
    tx_valid = 1'b0;
    tick(12);
    reset_n = 1'b0;
    #1;
    check_eq("midfcs_rst_txdata", txdata, 1);
    check_eq("midfcs_rst_busy", busy, 0);
    tick(20);
    reset_n = 1'b1;
    tick(30);
    check_eq("midfcs_no_frame_done", n_fd - base_fd, 0);
    check_eq("midfcs_idle_txdata", txdata, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
